hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS core.
//  Detects load-use hazards, squashes wrong-path fetches after a taken branch or jump, and
//  freezes the whole pipeline while data memory is busy. Drives the per-stage write, flush
//  and bubble enables. Sits beside the ID stage.
// PARAMETERS
//  FLUSH_CYCLES   1   cycles IF/ID is flushed per taken branch/jump (1..7)
//  MEM_STALL_MAX  15  consecutive mem_stall_i cycles before timeout_o is set (1..255)
// PORTS
//  clk_i            in   1   clock, rising edge
//  start_i          in   1   reset, asynchronous, active-low
//  IDEX_MemRead_i   in   1   instruction in EX is a load
//  IDEX_RTaddr_i    in   5   load destination register (EX stage)
//  IFID_RSaddr_i    in   5   rs of instruction in ID
//  IFID_RTaddr_i    in   5   rt of instruction in ID
//  branch_i         in   1   taken branch/jump resolved in ID this cycle
//  mem_stall_i      in   1   data memory not ready; pipeline must hold
//  PC_write_o       out  1   PC update enable
//  IFID_write_o     out  1   IF/ID load enable
//  IFID_flush_o     out  1   IF/ID clear (loads a nop)
//  IDEX_write_o     out  1   ID/EX load enable
//  IDEX_bubble_o    out  1   zero the control fields loaded into ID/EX
//  EXMEM_write_o    out  1   EX/MEM load enable
//  timeout_o        out  1   sticky: memory stall exceeded MEM_STALL_MAX
//  stall_cnt_o      out  32  PC-stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - While start_i=0: state=RUN, fcnt=0, wcnt=0, timeout_o=0, stall_cnt_o=0.
//    Outputs forced: PC_write_o=0, IFID_write_o=0, IFID_flush_o=0, IDEX_write_o=1,
//    IDEX_bubble_o=1, EXMEM_write_o=1.
//  - Outputs are Mealy: combinational from state + inputs, so they act in the same cycle.
//    State and counters update on posedge clk_i.
//  - Default (RUN, no event): all write enables 1; flush=0; bubble=0.
//  - Load-use: luse = IDEX_MemRead_i & (IDEX_RTaddr_i != 0)
//              & (IDEX_RTaddr_i == IFID_RSaddr_i | IDEX_RTaddr_i == IFID_RTaddr_i).
//  - Priority per cycle: mem_stall_i > branch_i > luse.
//  - Outputs under each condition:
//      mem_stall_i=1 : every *_write_o=0, flush=0, bubble=0; all stages hold.
//      branch_i (RUN): IFID_flush_o=1, PC_write_o=1, IFID_write_o=1.
//                      If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1.
//      luse (RUN)    : PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1. Lasts exactly 1 cycle,
//                      because the bubble clears IDEX_MemRead next cycle.
//  - States:
//      RUN     : normal operation.
//      FLUSH   : IFID_flush_o=1, PC_write_o=1, IDEX_bubble_o=1. branch_i and luse ignored.
//                fcnt decrements each cycle; when fcnt==1, next state is RUN.
//      MEMWAIT : entered from any state when mem_stall_i=1; the prior state is saved as the
//                resume state and fcnt is frozen. wcnt increments while mem_stall_i=1,
//                saturating at MEM_STALL_MAX. If wcnt reaches MEM_STALL_MAX, timeout_o is set
//                and held until reset; the pipeline stays frozen.
//                When mem_stall_i=0 in MEMWAIT: outputs follow the resume state's rules in that
//                same cycle, wcnt=0, and the next state is resume/its successor.
//  - Simultaneous branch_i and luse: flush wins; no stall cycle is inserted.
//  - Reset mid-FLUSH or mid-MEMWAIT: state returns to RUN immediately; timeout_o clears.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    stall_cnt_o increments each cycle with start_i=1 and PC_write_o=0.
//    Saturates at 32'hFFFFFFFF; reset to 0.
//  HAZARD_PERF_CNT_EN undefined:
//    stall_cnt_o tied to 32'd0; no counter flops are built.
// TESTING
//  T1 Reset: start_i=0 for 3 cycles, then 1 -> outputs match reset list; next idle cycle has all
//     write enables 1.
//  T2 Load-use: IDEX_MemRead_i=1, IDEX_RTaddr_i=8, IFID_RSaddr_i=8
//     -> 1 cycle with PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; next cycle back to normal.
//     Repeat with IDEX_RTaddr_i=0 -> no stall.
//  T3 Branch, FLUSH_CYCLES=3: branch_i pulse -> IFID_flush_o=1 for exactly 3 cycles.
//     A branch_i or luse during cycles 2-3 causes no extra flush or stall.
//  T4 Memory stall inside flush: mem_stall_i=1 for 4 cycles during FLUSH cycle 2
//     -> all enables 0 for 4 cycles, then the 2 remaining flush cycles complete.
//  T5 Timeout, MEM_STALL_MAX=15: mem_stall_i held 20 cycles -> timeout_o rises on the 15th
//     stalled cycle and stays 1 after mem_stall_i drops; clears only on start_i=0.
//  T6 Perf counter, HAZARD_PERF_CNT_EN defined: run T2 then T4 -> stall_cnt_o=5.
//     Macro undefined -> stall_cnt_o=0 throughout.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Purpose : bundles the hazard controller's pipeline-facing signals.
//           master modport: the pipeline side, drives hazard inputs and receives enables.
//           slave modport : the hazard controller itself.
// Signals : IDEX_MemRead_i, IDEX_RTaddr_i[4:0], IFID_RSaddr_i[4:0], IFID_RTaddr_i[4:0],
//           branch_i, mem_stall_i (to controller);
//           PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o, IDEX_bubble_o,
//           EXMEM_write_o, timeout_o, stall_cnt_o[31:0] (from controller).
interface hazard_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RTaddr_i;
  logic [4:0]  IFID_RSaddr_i;
  logic [4:0]  IFID_RTaddr_i;
  logic        branch_i;
  logic        mem_stall_i;
  logic        PC_write_o;
  logic        IFID_write_o;
  logic        IFID_flush_o;
  logic        IDEX_write_o;
  logic        IDEX_bubble_o;
  logic        EXMEM_write_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i, branch_i, mem_stall_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o, IDEX_bubble_o, EXMEM_write_o,
    input  timeout_o, stall_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i, branch_i, mem_stall_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o, IDEX_bubble_o, EXMEM_write_o,
    output timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline sequencer for the 5-stage MIPS core. Detects load-use hazards, flushes
//           IF/ID after taken branches/jumps and freezes the pipeline during memory stalls.
//           All enables are Mealy (state + current inputs); state updates on posedge clk_i.
// Ports   : clk_i   - clock, rising edge
//           start_i - asynchronous active-low reset
//           hz      - hazard_ctrl_if.slave (hazard inputs, stage enables, timeout, stall count)
// Params  : FLUSH_CYCLES  (1..7)   IF/ID flush cycles per taken branch/jump
//           MEM_STALL_MAX (1..255) consecutive stalled cycles before timeout_o is set
// Macro   : HAZARD_PERF_CNT_EN - when defined, stall_cnt_o counts cycles with PC_write_o=0
//           (saturating); when undefined, stall_cnt_o is tied to zero.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned MEM_STALL_MAX = 15
) (
  input logic          clk_i,
  input logic          start_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WcntMax  = 8'(MEM_STALL_MAX);

  state_e     r_state, w_state_d;
  state_e     r_resume, w_resume_d;
  state_e     w_eff_state;
  logic [2:0] r_fcnt, w_fcnt_d;
  logic [7:0] r_wcnt, w_wcnt_d;
  logic       r_timeout, w_timeout_d;
  logic       w_timeout_hit;
  logic       w_luse;

  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_write, w_idex_bubble, w_exmem_write;

  assign w_luse = hz.IDEX_MemRead_i && (hz.IDEX_RTaddr_i != 5'd0) &&
                  ((hz.IDEX_RTaddr_i == hz.IFID_RSaddr_i) ||
                   (hz.IDEX_RTaddr_i == hz.IFID_RTaddr_i));

  // While waiting on memory, behaviour is governed by the state that was interrupted.
  assign w_eff_state = (r_state == StMemWait) ? r_resume : r_state;

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_exmem_write = 1'b1;
    w_state_d     = r_state;
    w_resume_d    = r_resume;
    w_fcnt_d      = r_fcnt;
    w_wcnt_d      = r_wcnt;
    w_timeout_d   = r_timeout;
    w_timeout_hit = 1'b0;

    if (!start_i) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end else if (hz.mem_stall_i) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_write  = 1'b0;
      w_exmem_write = 1'b0;
      w_state_d     = StMemWait;
      w_resume_d    = w_eff_state;
      if (r_wcnt < WcntMax) begin
        w_wcnt_d = r_wcnt + 8'd1;
      end
      // This stalled cycle is the one that brings wcnt up to the limit.
      if (r_wcnt == (WcntMax - 8'd1)) begin
        w_timeout_hit = 1'b1;
        w_timeout_d   = 1'b1;
      end
    end else begin
      w_wcnt_d = 8'd0;
      case (w_eff_state)
        StFlush: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_fcnt_d      = r_fcnt - 3'd1;
          w_state_d     = (r_fcnt <= 3'd1) ? StRun : StFlush;
        end
        default: begin
          w_state_d = StRun;
          if (hz.branch_i) begin
            w_ifid_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_d = StFlush;
              w_fcnt_d  = FcntInit;
            end
          end else if (w_luse) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state   <= StRun;
      r_resume  <= StRun;
      r_fcnt    <= 3'd0;
      r_wcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_resume  <= w_resume_d;
      r_fcnt    <= w_fcnt_d;
      r_wcnt    <= w_wcnt_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign hz.PC_write_o    = w_pc_write;
  assign hz.IFID_write_o  = w_ifid_write;
  assign hz.IFID_flush_o  = w_ifid_flush;
  assign hz.IDEX_write_o  = w_idex_write;
  assign hz.IDEX_bubble_o = w_idex_bubble;
  assign hz.EXMEM_write_o = w_exmem_write;
  assign hz.timeout_o     = r_timeout | w_timeout_hit;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_stall_cnt <= 32'd0;
    end else if (!w_pc_write && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_o = r_stall_cnt;
`else
  assign hz.stall_cnt_o = 32'd0;
`endif

endmodule
